inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the decoder and supplies its 32-bit instruction word.
- Owns the program counter and issues word requests to instruction memory over a req/ack handshake.
- Buffers fetched words in a 2-entry FIFO and presents them to decode over a valid/ready handshake.
- Accepts a PC redirect from execute for branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- XLEN, 32, width of PC, address and instruction paths.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- imem_req  output  1  instruction memory request valid.
- imem_addr  output  XLEN  word address of the request; bits [1:0] always 0.
- imem_ack  input  1  memory returns data this cycle for the outstanding request.
- imem_rdata  input  XLEN  instruction word; valid only when imem_ack=1.
- redirect_valid  input  1  branch/jump taken; redirect PC this cycle.
- redirect_pc  input  XLEN  redirect target.
- inst_valid  output  1  instr and inst_pc hold a valid entry.
- inst_ready  input  1  decode accepts the entry this cycle.
- instr  output  XLEN  instruction word to the decoder.
- inst_pc  output  XLEN  PC of instr.
- fetch_fault  output  1  misaligned redirect flag (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clk edge):
  - pc=RESET_PC, FIFO empty, no request outstanding, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, instr=0, inst_pc=0, fetch_fault=0.
  - Reset asserted mid-request drops the outstanding request and its data. Memory must tolerate req falling without ack.
- FSM states:
  - IDLE: entered only from reset. Moves to FETCH on the first cycle with reset=1.
  - FETCH: imem_req=1 when (FIFO count + outstanding) < 2.
  - DISCARD: waits out a stale request after a redirect.
- Request rules:
  - At most one request outstanding.
  - Once raised, imem_req and imem_addr stay stable until the imem_ack cycle; ack may arrive in the same cycle as req.
  - On ack in FETCH: push {pc, imem_rdata} into the FIFO and set pc=pc+4 (wraps modulo 2^32, no flag).
  - imem_req is driven combinationally from registered state, so a new request may follow an ack back-to-back when there is room.
- Output timing:
  - inst_valid/instr/inst_pc come from the FIFO head register.
  - Ack in cycle t gives inst_valid=1 in cycle t+1 when the FIFO was empty.
  - Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - Full FIFO (2) with inst_ready=0: no request issued; output held stable.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed the same edge; inst_valid=0 the next cycle.
  - pc loaded with redirect_pc[XLEN-1:2],2'b00.
  - If a request is outstanding and imem_ack=0: go to DISCARD and keep imem_req/imem_addr at the old values.
  - In DISCARD, the ack is consumed and its data dropped, then return to FETCH and request the new pc.
  - If imem_ack=1 in the redirect cycle: that data is dropped; stay/return to FETCH.
  - A further redirect in DISCARD updates pc only (last redirect wins).
  - A pop in the redirect cycle is honoured by decode; the flush overrides the FIFO state.

Optional Feature:
- Macro: INST_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky), flushes the FIFO and stops new requests; an outstanding request is discarded as usual.
  - The next redirect with an aligned target clears fetch_fault and resumes fetch.
- Undefined:
  - fetch_fault is tied 0.
  - Low bits of redirect_pc are silently cleared and fetch continues.

Test Plan:
- Reset release, RESET_PC=0, memory acks same cycle with rdata=32'h00500093 → imem_addr=0,4,8... on consecutive cycles; inst_valid=1 one cycle after the first ack with instr=32'h00500093, inst_pc=0.
- inst_ready=0 for 5 cycles, 1-cycle ack latency → exactly two acks accepted (pc 0,4); imem_req=0 afterwards; instr/inst_pc stable; on release pops in order pc 0 then 4.
- Redirect to 32'h100 while request to 32'h8 is outstanding, ack 2 cycles later → DISCARD; data for 0x8 never appears on instr; next imem_addr=32'h100.
- Redirect coincident with ack → acked word dropped; inst_valid=0 next cycle; next request addr = redirect target.
- Reset pulled low while imem_req=1 and FIFO holds 2 entries → next cycle imem_req=0, inst_valid=0; after release, fetch restarts at RESET_PC.
- With INST_FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102 → fetch_fault=1, no imem_req; then redirect_pc=32'h200 → fetch_fault=0, imem_addr=32'h200. Without the macro, redirect_pc=32'h102 → imem_addr=32'h100, fetch_fault=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack, buffers two entries for decode.
// Latency: an ack in cycle t presents the word to decode in cycle t+1 when the buffer was empty.
// Backpressure: no new request while the buffer plus any outstanding request fills both slots; the head is held until decode accepts it.
// Optional build macro INST_FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises sticky fetch_fault and stops fetching.

module inst_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault
);

    // Word stride and the mask that forces a target onto a word boundary.
    localparam logic [XLEN-1:0] WORD_STEP = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic            outstanding;

    // Two-entry buffer: head feeds decode directly, tail is the overflow slot.
    logic [1:0]      count;
    logic [XLEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] tail_instr;
    logic [XLEN-1:0] tail_pc;

    logic            fetch_blocked;
    logic            buf_room;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & WORD_MASK;

    // A new request needs a free slot counting the one in flight; an issued request
    // is held (address included) until memory acks it, whatever else happens.
    assign buf_room  = (count != 2'd2);
    assign imem_req  = outstanding | ((state == S_FETCH) & buf_room & ~fetch_blocked);
    assign imem_addr = outstanding ? req_addr : pc;

    // Only data for the current PC stream is kept; a redirect in the ack cycle or
    // an ack of a stale request (DISCARD) is dropped.
    assign push = imem_req & imem_ack & (state == S_FETCH) & ~redirect_valid;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready;
    assign instr      = head_instr;
    assign inst_pc    = head_pc;

    // Fetch control: state, PC and the single outstanding-request tracker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            outstanding <= 1'b0;
        end else begin
            // A raised request that was not acked this cycle stays in flight.
            outstanding <= imem_req & ~imem_ack;
            if (imem_req & ~imem_ack) begin
                req_addr <= imem_addr;
            end

            // Redirect wins over sequential advance; the last redirect always sets the PC.
            if (redirect_valid) begin
                pc <= redirect_aligned;
            end else if (push) begin
                pc <= pc + WORD_STEP;
            end

            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    // The in-flight request belongs to the old stream; wait out its ack.
                    if (redirect_valid & imem_req & ~imem_ack) begin
                        state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Instruction buffer: push at tail, pop from head, flush on redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= 2'd0;
            head_instr <= {XLEN{1'b0}};
            head_pc    <= {XLEN{1'b0}};
            tail_instr <= {XLEN{1'b0}};
            tail_pc    <= {XLEN{1'b0}};
        end else if (redirect_valid) begin
            // Any pop this cycle has already been taken by decode; the flush empties the rest.
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= imem_rdata;
                        head_pc    <= pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever remains.
                    if (count == 2'd1) begin
                        head_instr <= imem_rdata;
                        head_pc    <= pc;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INST_FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    logic redirect_misaligned;

    assign redirect_misaligned = |redirect_pc[1:0];

    // Sticky misalignment fault: set by a misaligned redirect, cleared by the next aligned one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= redirect_misaligned;
        end
    end

    assign fetch_blocked = fault_q;
    assign fetch_fault   = fault_q;
`else
    assign fetch_blocked = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

endmodule
